decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 One clock; reset is synchronous and active-high, named clk and rst; no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_valid  input  1  fetch presents an instruction.
REQ-005 o_ready  output  1  decode accepts the instruction this cycle.
REQ-006 i_inst  input  32  RV32I instruction word from fetch.
REQ-007 i_pc  input  32  PC of i_inst.
REQ-008 i_flush  input  1  control-transfer redirect; kill held and incoming instruction.
REQ-009 o_rs1_index  output  5  register file read index 1, equal to i_inst[19:15].
REQ-010 o_rs2_index  output  5  register file read index 2, equal to i_inst[24:20].
REQ-011 i_rs1_data  input  32  register file read data 1, combinational from o_rs1_index.
REQ-012 i_rs2_data  input  32  register file read data 2, combinational from o_rs2_index.
REQ-013 i_wb_enable  input  1  writeback write enable, same signal that drives the register file.
REQ-014 i_wb_index  input  5  writeback destination index.
REQ-015 i_wb_data  input  32  writeback data.
REQ-016 o_valid  output  1  decoded instruction present for execute.
REQ-017 i_ready  input  1  execute accepts the decoded instruction.
REQ-018 o_pc  output  32  registered PC.
REQ-019 o_inst  output  32  registered raw instruction, used by execute for control decode.
REQ-020 o_rs1  output  32  rs1 operand value.
REQ-021 o_rs2  output  32  rs2 operand value.
REQ-022 o_imm  output  32  sign-extended immediate.
REQ-023 o_rd  output  5  destination index; 0 when there is no writeback.
REQ-024 o_illegal  output  1  unsupported opcode.

Function
REQ-025 Handshake:
- o_ready = !o_valid || i_ready (combinational).
- accept = i_valid && o_ready && !i_flush.
REQ-026 Each edge:
- On accept: load all output registers from i_inst/i_pc; o_valid becomes 1.
- Else if i_ready or i_flush: o_valid becomes 0.
- Else: hold.
REQ-027 i_flush clears o_valid next cycle and drops any same-cycle incoming instruction; flush wins over accept.
REQ-028 Operand bypass at accept: when i_wb_enable && i_wb_index != 0 && i_wb_index == rsN index, the operand is taken from i_wb_data, otherwise from i_rsN_data; index 0 always yields 0.
REQ-029 Held refresh:
- Applies while o_valid && !i_ready and no accept.
- Each edge with i_wb_enable && i_wb_index != 0 && i_wb_index == the held rsN index reloads o_rsN with i_wb_data.
REQ-030 Immediate is selected by opcode i_inst[6:0]:
- I-type for 0000011, 0010011, 1100111, 1110011.
- S-type for 0100011; B-type for 1100011.
- U-type for 0110111, 0010111; J-type for 1101111.
- 0 for 0110011, 0001111.
- All formats sign-extended from bit 31.
REQ-031 o_rd = i_inst[11:7], except 0 for 1100011 and 0100011.
REQ-032 o_illegal = 1 and o_rd = 0 for any opcode not listed in REQ-030, including the low two bits != 11; o_imm = 0 in that case.
REQ-033 Latency: exactly one cycle from accept to o_valid; back-to-back acceptance sustains one instruction per cycle when i_ready = 1.

Reset
REQ-034 While rst = 1 at an edge, all registered outputs (o_valid, o_pc, o_inst, o_rs1, o_rs2, o_imm, o_rd, o_illegal) become 0 regardless of i_valid or i_flush; o_ready then reads 1.
REQ-035 Reset asserted mid-stall discards the held instruction; the first accept after reset release completes in one cycle.

Verification
REQ-036 Reset: rst = 1 for 2 cycles with i_valid = 1 -> o_valid = 0, o_ready = 1, all data outputs 0.
REQ-037 Decode and bypass:
- Regfile x1 = 0xDEADBEEF; accept 0xFFF08293 (addi x5,x1,-1) -> next cycle o_valid = 1, o_rs1 = 0xDEADBEEF, o_imm = 0xFFFFFFFF, o_rd = 5.
- Repeat with same-cycle wb x1 = 0x1234 -> o_rs1 = 0x1234.
- wb to x0 = 0xBEEF -> operand 0.
REQ-038 Immediate and illegal:
- 0xFE000EE3 (beq x0,x0,-4) -> o_imm = 0xFFFFFFFC, o_rd = 0, o_illegal = 0.
- 0x00000000 -> o_illegal = 1, o_rd = 0.
REQ-039 Stall:
- i_ready = 0 for 3 cycles -> o_ready = 0, outputs stable.
- wb x1 = 0xCAFE mid-stall -> held o_rs1 = 0xCAFE next cycle.
- i_ready = 1 -> transfer; o_valid = 0 if no new accept.
REQ-040 Flush: i_flush = 1 with i_valid = 1 and o_valid = 1 -> next cycle o_valid = 0; neither instruction appears; the next accept decodes normally.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: registers one instruction per cycle with operand read,
// writeback bypass, immediate generation and illegal-opcode detection.
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_inst,
   input  logic [31:0] i_pc,
   input  logic        i_flush,
   output logic [4:0]  o_rs1_index,
   output logic [4:0]  o_rs2_index,
   input  logic [31:0] i_rs1_data,
   input  logic [31:0] i_rs2_data,
   input  logic        i_wb_enable,
   input  logic [4:0]  i_wb_index,
   input  logic [31:0] i_wb_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst,
   output logic [31:0] o_rs1,
   output logic [31:0] o_rs2,
   output logic [31:0] o_imm,
   output logic [4:0]  o_rd,
   output logic        o_illegal
);

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_ZERO
   } imm_fmt_e;

   logic        valid_q, valid_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rs2_q, rs2_d;
   logic [31:0] imm_q, imm_d;
   logic [4:0]  rd_q, rd_d;
   logic        illegal_q, illegal_d;

   logic        accept;
   imm_fmt_e    fmt;
   logic        dec_illegal;
   logic [31:0] dec_imm;
   logic [4:0]  dec_rd;
   logic [31:0] dec_rs1;
   logic [31:0] dec_rs2;
   logic [4:0]  held_rs1_idx;
   logic [4:0]  held_rs2_idx;

   assign o_ready     = !valid_q || i_ready;
   assign accept      = i_valid && o_ready && !i_flush;
   assign o_rs1_index = i_inst[19:15];
   assign o_rs2_index = i_inst[24:20];
   assign held_rs1_idx = inst_q[19:15];
   assign held_rs2_idx = inst_q[24:20];

   // Opcode classification; anything not listed (incl. low bits != 11) is illegal.
   always_comb begin
      fmt         = FMT_NONE;
      dec_illegal = 1'b0;
      unique case (i_inst[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: fmt = FMT_I;
         7'b0100011:                                     fmt = FMT_S;
         7'b1100011:                                     fmt = FMT_B;
         7'b0110111, 7'b0010111:                         fmt = FMT_U;
         7'b1101111:                                     fmt = FMT_J;
         7'b0110011, 7'b0001111:                         fmt = FMT_ZERO;
         default:                                        dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      dec_imm = '0;
      unique case (fmt)
         FMT_I: dec_imm = {{20{i_inst[31]}}, i_inst[31:20]};
         FMT_S: dec_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         FMT_B: dec_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
         FMT_U: dec_imm = {i_inst[31:12], 12'b0};
         FMT_J: dec_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
         default: dec_imm = '0;
      endcase
   end

   always_comb begin
      if (dec_illegal || fmt == FMT_S || fmt == FMT_B) begin
         dec_rd = '0;
      end else begin
         dec_rd = i_inst[11:7];
      end
   end

   // Operand read with same-cycle writeback bypass; x0 always reads zero.
   always_comb begin
      if (o_rs1_index == 5'd0) begin
         dec_rs1 = '0;
      end else if (i_wb_enable && i_wb_index == o_rs1_index) begin
         dec_rs1 = i_wb_data;
      end else begin
         dec_rs1 = i_rs1_data;
      end
      if (o_rs2_index == 5'd0) begin
         dec_rs2 = '0;
      end else if (i_wb_enable && i_wb_index == o_rs2_index) begin
         dec_rs2 = i_wb_data;
      end else begin
         dec_rs2 = i_rs2_data;
      end
   end

   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      imm_d     = imm_q;
      rd_d      = rd_q;
      illegal_d = illegal_q;
      if (accept) begin
         valid_d   = 1'b1;
         pc_d      = i_pc;
         inst_d    = i_inst;
         rs1_d     = dec_rs1;
         rs2_d     = dec_rs2;
         imm_d     = dec_imm;
         rd_d      = dec_rd;
         illegal_d = dec_illegal;
      end else if (i_ready || i_flush) begin
         valid_d = 1'b0;
      end else if (valid_q && i_wb_enable && i_wb_index != 5'd0) begin
         // Stalled instruction keeps its operands current with later writebacks.
         if (i_wb_index == held_rs1_idx) begin
            rs1_d = i_wb_data;
         end
         if (i_wb_index == held_rs2_idx) begin
            rs2_d = i_wb_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         inst_q    <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         rd_q      <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_q     <= imm_d;
         rd_q      <= rd_d;
         illegal_q <= illegal_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_pc      = pc_q;
   assign o_inst    = inst_q;
   assign o_rs1     = rs1_q;
   assign o_rs2     = rs2_q;
   assign o_imm     = imm_q;
   assign o_rd      = rd_q;
   assign o_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with a small behavioural
// register file driving the read-data ports.
module tb_decode_stage;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_inst;
   logic [31:0] i_pc;
   logic        i_flush;
   logic [4:0]  o_rs1_index;
   logic [4:0]  o_rs2_index;
   logic [31:0] i_rs1_data;
   logic [31:0] i_rs2_data;
   logic        i_wb_enable;
   logic [4:0]  i_wb_index;
   logic [31:0] i_wb_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic [31:0] o_rs1;
   logic [31:0] o_rs2;
   logic [31:0] o_imm;
   logic [4:0]  o_rd;
   logic        o_illegal;

   logic [31:0] rf [32];
   int unsigned n_cmp;
   int unsigned n_bad;

   localparam logic [31:0] ADDI_X1  = 32'hFFF08293; // addi x5,x1,-1
   localparam logic [31:0] ADDI_X0  = 32'hFFF00293; // addi x5,x0,-1
   localparam logic [31:0] BEQ      = 32'hFE000EE3; // beq x0,x0,-4
   localparam logic [31:0] SW       = 32'h0020A423; // sw x2,8(x1)
   localparam logic [31:0] LUI      = 32'h12345537; // lui x10,0x12345

   decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_inst      (i_inst),
      .i_pc        (i_pc),
      .i_flush     (i_flush),
      .o_rs1_index (o_rs1_index),
      .o_rs2_index (o_rs2_index),
      .i_rs1_data  (i_rs1_data),
      .i_rs2_data  (i_rs2_data),
      .i_wb_enable (i_wb_enable),
      .i_wb_index  (i_wb_index),
      .i_wb_data   (i_wb_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_pc        (o_pc),
      .o_inst      (o_inst),
      .o_rs1       (o_rs1),
      .o_rs2       (o_rs2),
      .o_imm       (o_imm),
      .o_rd        (o_rd),
      .o_illegal   (o_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      i_rs1_data = rf[o_rs1_index];
      i_rs2_data = rf[o_rs2_index];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      i_valid = v;
      i_inst  = inst;
      i_pc    = pc;
   endtask

   task automatic wb(input logic en, input logic [4:0] idx, input logic [31:0] data);
      i_wb_enable = en;
      i_wb_index  = idx;
      i_wb_data   = data;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
      rf[0]  = 32'h5555_5555; // forces the bench to see x0 masking in the DUT
      rf[1]  = 32'hDEAD_BEEF;
      rf[2]  = 32'h0000_0222;
      rf[31] = 32'h3131_3131;
      rst = 1'b1;
      i_flush = 1'b0;
      i_ready = 1'b1;
      wb(1'b0, 5'd0, 32'h0);
      drive(1'b1, ADDI_X1, 32'h0000_0100);

      // Reset for two cycles with a valid instruction presented
      step();
      step();
      check("rst_valid",   {31'b0, o_valid},   32'h0);
      check("rst_ready",   {31'b0, o_ready},   32'h1);
      check("rst_pc",      o_pc,               32'h0);
      check("rst_inst",    o_inst,             32'h0);
      check("rst_rs1",     o_rs1,              32'h0);
      check("rst_rs2",     o_rs2,              32'h0);
      check("rst_imm",     o_imm,              32'h0);
      check("rst_rd",      {27'b0, o_rd},      32'h0);
      check("rst_illegal", {31'b0, o_illegal}, 32'h0);

      // Plain decode from the register file
      rst = 1'b0;
      check("rs1_index", {27'b0, o_rs1_index}, 32'd1);
      check("rs2_index", {27'b0, o_rs2_index}, 32'd31);
      step();
      check("addi_valid", {31'b0, o_valid}, 32'h1);
      check("addi_pc",    o_pc,             32'h0000_0100);
      check("addi_inst",  o_inst,           ADDI_X1);
      check("addi_rs1",   o_rs1,            32'hDEAD_BEEF);
      check("addi_rs2",   o_rs2,            32'h3131_3131);
      check("addi_imm",   o_imm,            32'hFFFF_FFFF);
      check("addi_rd",    {27'b0, o_rd},    32'd5);
      check("addi_ill",   {31'b0, o_illegal}, 32'h0);

      // Same-cycle writeback bypass, back-to-back accept
      drive(1'b1, ADDI_X1, 32'h0000_0104);
      wb(1'b1, 5'd1, 32'h0000_1234);
      step();
      check("byp_valid", {31'b0, o_valid}, 32'h1);
      check("byp_pc",    o_pc,             32'h0000_0104);
      check("byp_rs1",   o_rs1,            32'h0000_1234);

      // Writeback to x0 never bypasses; x0 reads zero
      drive(1'b1, ADDI_X0, 32'h0000_0108);
      wb(1'b1, 5'd0, 32'h0000_BEEF);
      step();
      check("x0_rs1", o_rs1, 32'h0);
      wb(1'b0, 5'd0, 32'h0);

      // Branch immediate
      drive(1'b1, BEQ, 32'h0000_0200);
      step();
      check("beq_imm", o_imm,             32'hFFFF_FFFC);
      check("beq_rd",  {27'b0, o_rd},     32'h0);
      check("beq_ill", {31'b0, o_illegal}, 32'h0);
      check("beq_rs2", o_rs2,             32'h0);

      // Store immediate
      drive(1'b1, SW, 32'h0000_0204);
      step();
      check("sw_imm", o_imm,         32'h0000_0008);
      check("sw_rd",  {27'b0, o_rd}, 32'h0);
      check("sw_rs2", o_rs2,         32'h0000_0222);

      // Illegal all-zero word
      drive(1'b1, 32'h0000_0000, 32'h0000_0208);
      step();
      check("ill_flag", {31'b0, o_illegal}, 32'h1);
      check("ill_rd",   {27'b0, o_rd},      32'h0);
      check("ill_imm",  o_imm,              32'h0);

      // Stall: accept addi, then hold for three cycles while a beq waits
      drive(1'b1, ADDI_X1, 32'h0000_0300);
      step();
      drive(1'b1, BEQ, 32'h0000_0304);
      i_ready = 1'b0;
      #1;
      check("stall_ready", {31'b0, o_ready}, 32'h0);
      step();
      check("stall1_valid", {31'b0, o_valid}, 32'h1);
      check("stall1_inst",  o_inst,           ADDI_X1);
      wb(1'b1, 5'd1, 32'h0000_CAFE);
      step();
      wb(1'b0, 5'd0, 32'h0);
      check("stall2_rs1",  o_rs1,  32'h0000_CAFE);
      check("stall2_pc",   o_pc,   32'h0000_0300);
      step();
      check("stall3_inst", o_inst, ADDI_X1);
      check("stall3_rs1",  o_rs1,  32'h0000_CAFE);
      check("stall3_imm",  o_imm,  32'hFFFF_FFFF);
      drive(1'b0, BEQ, 32'h0000_0304);
      i_ready = 1'b1;
      #1;
      check("release_ready", {31'b0, o_ready}, 32'h1);
      step();
      check("drain_valid", {31'b0, o_valid}, 32'h0);

      // Flush kills both the held and the incoming instruction
      drive(1'b1, ADDI_X1, 32'h0000_0400);
      step();
      i_ready = 1'b0;
      i_flush = 1'b1;
      drive(1'b1, BEQ, 32'h0000_0404);
      step();
      check("flush_valid", {31'b0, o_valid}, 32'h0);
      check("flush_inst",  o_inst,           ADDI_X1);
      i_flush = 1'b0;
      drive(1'b0, BEQ, 32'h0000_0404);
      step();
      check("post_flush_valid", {31'b0, o_valid}, 32'h0);
      i_ready = 1'b1;
      drive(1'b1, LUI, 32'h0000_0500);
      step();
      check("lui_valid", {31'b0, o_valid}, 32'h1);
      check("lui_imm",   o_imm,            32'h1234_5000);
      check("lui_rd",    {27'b0, o_rd},    32'd10);
      check("lui_pc",    o_pc,             32'h0000_0500);

      // Reset during a stall discards the held instruction
      i_ready = 1'b0;
      drive(1'b1, BEQ, 32'h0000_0600);
      step();
      rst = 1'b1;
      step();
      check("rst_stall_valid", {31'b0, o_valid}, 32'h0);
      check("rst_stall_inst",  o_inst,           32'h0);
      rst = 1'b0;
      drive(1'b1, SW, 32'h0000_0700);
      step();
      check("after_rst_valid", {31'b0, o_valid}, 32'h1);
      check("after_rst_imm",   o_imm,            32'h0000_0008);
      check("after_rst_pc",    o_pc,             32'h0000_0700);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
